// File: rtl/mac_pipe_pkg.sv
// Shared types and helpers for the mac_pipe multiply-add/accumulate engine.
package mac_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_MADD = 2'd0,
        MODE_ACC  = 2'd1
    } mac_mode_e;

    // Reserved mode encodings fold onto MADD.
    function automatic mac_mode_e decode_mode(input logic [1:0] mode);
        return (mode == 2'(MODE_ACC)) ? MODE_ACC : MODE_MADD;
    endfunction

    // Overflow of one addition, judged from the operand/result sign bits and the carry-out.
    function automatic logic mac_ovf(
        input logic is_signed,
        input logic x_msb,
        input logic y_msb,
        input logic sum_msb,
        input logic carry
    );
        if (is_signed) begin
            return (x_msb == y_msb) && (sum_msb != x_msb);
        end
        return carry;
    endfunction

endpackage

// File: rtl/mac_pipe_if.sv
// Input-beat and result handshake bundle for mac_pipe.
interface mac_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] c;
    logic [1:0]        mode;
    logic              last;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  data;
    logic              ovf;

    modport master (
        output in_valid, a, b, c, mode, last, out_ready,
        input  in_ready, out_valid, data, ovf
    );

    modport slave (
        input  in_valid, a, b, c, mode, last, out_ready,
        output in_ready, out_valid, data, ovf
    );
endinterface

// File: rtl/mac_pipe_mul.sv
// S1 operand register and S2 product register; kept separate so a DSP primitive can replace it.
module mac_pipe_mul
    import mac_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     a,
    input  logic [DATA_W-1:0]     b,
    input  logic [DATA_W-1:0]     c,
    input  logic [1:0]            mode,
    input  logic                  last,
    output logic                  s2_valid,
    output logic [2*DATA_W-1:0]   s2_prod,
    output logic [DATA_W-1:0]     s2_c,
    output mac_mode_e             s2_mode,
    output logic                  s2_last
);
    localparam int PROD_W = 2 * DATA_W;

    logic              s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0] s1_a_q, s1_a_d;
    logic [DATA_W-1:0] s1_b_q, s1_b_d;
    logic [DATA_W-1:0] s1_c_q, s1_c_d;
    mac_mode_e         s1_mode_q, s1_mode_d;
    logic              s1_last_q, s1_last_d;

    logic              s2_valid_q, s2_valid_d;
    logic [PROD_W-1:0] s2_prod_q, s2_prod_d;
    logic [DATA_W-1:0] s2_c_q, s2_c_d;
    mac_mode_e         s2_mode_q, s2_mode_d;
    logic              s2_last_q, s2_last_d;

    logic [PROD_W-1:0] a_ext, b_ext;

    always_comb begin
        // Extending to full product width first makes one unsigned multiply serve both modes.
        a_ext = {{DATA_W{(SIGNED != 0) && s1_a_q[DATA_W-1]}}, s1_a_q};
        b_ext = {{DATA_W{(SIGNED != 0) && s1_b_q[DATA_W-1]}}, s1_b_q};

        // NOTE: every output gets a hold default before any branch, so no latch is inferred.
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_c_d     = s1_c_q;
        s1_mode_d  = s1_mode_q;
        s1_last_d  = s1_last_q;
        s2_valid_d = s2_valid_q;
        s2_prod_d  = s2_prod_q;
        s2_c_d     = s2_c_q;
        s2_mode_d  = s2_mode_q;
        s2_last_d  = s2_last_q;

        if (en) begin
            s1_valid_d = in_valid;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_c_d     = c;
            s1_mode_d  = decode_mode(mode);
            s1_last_d  = last;
            s2_valid_d = s1_valid_q;
            s2_prod_d  = a_ext * b_ext;
            s2_c_d     = s1_c_q;
            s2_mode_d  = s1_mode_q;
            s2_last_d  = s1_last_q;
        end
    end

    // NOTE: registers update only with non-blocking assignments so all flops sample the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_c_q     <= '0;
            s1_mode_q  <= MODE_MADD;
            s1_last_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_c_q     <= '0;
            s2_mode_q  <= MODE_MADD;
            s2_last_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_c_q     <= s1_c_d;
            s1_mode_q  <= s1_mode_d;
            s1_last_q  <= s1_last_d;
            s2_valid_q <= s2_valid_d;
            s2_prod_q  <= s2_prod_d;
            s2_c_q     <= s2_c_d;
            s2_mode_q  <= s2_mode_d;
            s2_last_q  <= s2_last_d;
        end
    end

    assign s2_valid = s2_valid_q;
    assign s2_prod  = s2_prod_q;
    assign s2_c     = s2_c_q;
    assign s2_mode  = s2_mode_q;
    assign s2_last  = s2_last_q;

endmodule

// File: rtl/mac_pipe.sv
// Pipelined multiply-add / dot-product engine: handshake, S3 adder/accumulator and packet state.
module mac_pipe
    import mac_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2 * DATA_W + 4,
    parameter int SIGNED = 0
) (
    input  logic       clk,
    input  logic       rst,
    mac_pipe_if.slave  bus
);
    localparam int PROD_W = 2 * DATA_W;

    logic              en;
    logic              s2_valid;
    logic [PROD_W-1:0] s2_prod;
    logic [DATA_W-1:0] s2_c;
    mac_mode_e         s2_mode;
    logic              s2_last;

    logic              out_valid_q, out_valid_d;
    logic [ACC_W-1:0]  data_q, data_d;
    logic              ovf_q, ovf_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              acc_active_q, acc_active_d;
    logic              acc_ovf_q, acc_ovf_d;

    logic [ACC_W-1:0]  prod_ext, c_ext, base;
    logic [ACC_W:0]    sum_full;
    logic              is_acc, continuing, add_ovf, ovf_run;

    // A stalled result freezes the whole pipeline, so the input side stalls in the same cycle.
    assign en          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = en;

    mac_pipe_mul #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_mul (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .in_valid (bus.in_valid),
        .a        (bus.a),
        .b        (bus.b),
        .c        (bus.c),
        .mode     (bus.mode),
        .last     (bus.last),
        .s2_valid (s2_valid),
        .s2_prod  (s2_prod),
        .s2_c     (s2_c),
        .s2_mode  (s2_mode),
        .s2_last  (s2_last)
    );

    always_comb begin
        prod_ext   = {{(ACC_W - PROD_W){(SIGNED != 0) && s2_prod[PROD_W-1]}}, s2_prod};
        c_ext      = {{(ACC_W - DATA_W){(SIGNED != 0) && s2_c[DATA_W-1]}}, s2_c};
        is_acc     = (s2_mode == MODE_ACC);
        continuing = is_acc && acc_active_q;
        base       = continuing ? acc_q : c_ext;
        sum_full   = {1'b0, base} + {1'b0, prod_ext};
        add_ovf    = mac_ovf(SIGNED != 0, base[ACC_W-1], prod_ext[ACC_W-1],
                             sum_full[ACC_W-1], sum_full[ACC_W]);
        // Overflow is sticky only within an open packet; a fresh packet or MADD starts clean.
        ovf_run    = add_ovf || (continuing && acc_ovf_q);

        out_valid_d  = out_valid_q;
        data_d       = data_q;
        ovf_d        = ovf_q;
        acc_d        = acc_q;
        acc_active_d = acc_active_q;
        acc_ovf_d    = acc_ovf_q;

        if (en) begin
            out_valid_d = 1'b0;
            if (s2_valid) begin
                if (is_acc && !s2_last) begin
                    acc_d        = sum_full[ACC_W-1:0];
                    acc_active_d = 1'b1;
                    acc_ovf_d    = ovf_run;
                end else begin
                    out_valid_d = 1'b1;
                    data_d      = sum_full[ACC_W-1:0];
                    ovf_d       = ovf_run;
                    if (is_acc) begin
                        acc_active_d = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            data_q       <= '0;
            ovf_q        <= 1'b0;
            acc_q        <= '0;
            acc_active_q <= 1'b0;
            acc_ovf_q    <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            data_q       <= data_d;
            ovf_q        <= ovf_d;
            acc_q        <= acc_d;
            acc_active_q <= acc_active_d;
            acc_ovf_q    <= acc_ovf_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data      = data_q;
    assign bus.ovf       = ovf_q;

endmodule

// File: doc/mac_pipe.md
# mac_pipe

Parametrised pipelined multiply-add/accumulate engine with valid/ready handshake on both sides. It computes either a single-beat `a*b+c` or a multi-beat dot product `c + Σ a*b` closed by `last`. Overflow is flagged per result. It sits between the sample-input registers and the result bus, and is the general-purpose arithmetic datapath for all multi-operand math blocks.

## Interface
- `DATA_W`, 8: width of operands `a`, `b`, `c`.
- `ACC_W`, 2*DATA_W+4: width of result and internal accumulator; must be ≥ 2*DATA_W+1.
- `SIGNED`, 0: 0 = unsigned operands; 1 = two's-complement operands, result and overflow.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge; no negedge logic.
- `rst`, in, 1: asynchronous, active-high reset.
- `in_valid`, in, 1: an input beat is present.
- `in_ready`, out, 1: the block accepts a beat this cycle.
- `a`, `b`, `c`, in, DATA_W each: operands. `c` is used only on MADD beats and on the first beat of an ACC packet.
- `mode`, in, 2: 0 = MADD, 1 = ACC; 2 and 3 are reserved and treated as MADD.
- `last`, in, 1: closes an ACC packet. Ignored in MADD.
- `out_valid`, out, 1: result present.
- `out_ready`, in, 1: downstream accepts the result.
- `data`, out, ACC_W: result.
- `ovf`, out, 1: overflow flag, qualified by `out_valid`.

## Operation
- A beat is accepted when `in_valid && in_ready`.
- Pipeline stages:
  - S1 registers `a`, `b`, `c`, `mode`, `last` and a valid bit.
  - S2 registers the product, width 2*DATA_W, signed or unsigned per `SIGNED`.
  - S3 is the add/accumulate stage and the output register.
- Extension to ACC_W: product and `c` are sign-extended when `SIGNED=1`, zero-extended otherwise.
- MADD beat: result = `ext(c) + ext(prod)`. Always produces an output. The accumulator is untouched, even mid-packet, so MADD beats may be interleaved into an open ACC packet.
- ACC beat:
  - If the accumulator is idle (`acc_active=0`): sum = `ext(c) + ext(prod)`. Otherwise: sum = `acc + ext(prod)`.
  - If `last=0`: `acc <= sum`, `acc_active <= 1`, no output.
  - If `last=1`: `data <= sum`, `out_valid <= 1`, `acc_active <= 0`. A single-beat packet with `last=1` behaves like MADD.
- Arithmetic wraps modulo 2^ACC_W.
- `ovf` is sticky across the beats of one packet and is delivered with the closing result; it clears when a new packet or MADD beat starts. It is set by:
  - unsigned: carry out of ACC_W;
  - signed: two's-complement overflow of any addition in that result.
- Global enable `en = !out_valid || out_ready`. All stages advance only when `en=1`, and `in_ready = en`. Bubbles propagate as valid=0.
- Reset values:
  - outputs: `out_valid=0`, `data=0`, `ovf=0`, `in_ready=1`;
  - internal: `acc=0`, `acc_active=0`, all stage valid bits 0.
- Reset asserted mid-packet discards the partial accumulation and all in-flight beats. The next ACC beat starts a new packet using its `c`.

## Timing
- Beat accepted at edge k: S1 at k, S2 at k+1, `out_valid`/`data`/`ovf` update at k+2.
- Throughput is one beat per cycle while `out_ready=1`.
- With `out_valid=1 && out_ready=0`:
  - `in_ready` drops in the same cycle (combinational from registered `out_valid` and `out_ready`);
  - the whole pipeline holds;
  - `data` and `ovf` stay stable until the edge where `out_ready=1`.
- Inputs need not be held after acceptance.
- `out_valid` deasserts at the edge where the result is taken, unless S2 delivers a new result on that same edge.
- Results leave in acceptance order; non-last ACC beats produce no output slot.

## Structure
- Package `mac_pipe_pkg`:
  - `typedef enum logic [1:0] {MODE_MADD=0, MODE_ACC=1} mac_mode_e`;
  - function `mac_ovf()` for signed/unsigned overflow detection.
- Sub-module `mac_pipe_mul`: the S1→S2 registered multiplier with an enable and a `SIGNED` parameter, so it can be swapped for a DSP primitive.
- Top level holds the handshake, S3 adder/accumulator and packet state.

## Test plan
- MADD, unsigned, defaults: a=200, b=100, c=50 → `data`=20050, `ovf`=0, `out_valid` at edge k+2.
- Four back-to-back MADD beats (a=1..4, b=10, c=0), with `out_ready` low for 3 cycles after the first result:
  - `in_ready` low exactly while the result is stalled;
  - outputs 10, 20, 30, 40 in order, none lost or duplicated.
- ACC packet (3,4,c=10), (5,6), (7,8,last) → single output 108; no `out_valid` for the first two beats.
- Overflow, unsigned, ACC_W=20: 17 ACC beats of a=b=255, c=0, last on the 17th → `data`=56849, `ovf`=1. A following MADD 1*1+0 gives `ovf`=0.
- SIGNED=1: a=-128, b=-128, c=-1 → `data`=16383. Also a=127, b=-128, c=0 → `data`=-16256 (sign-extended), `ovf`=0.
- `rst` pulsed between beats 2 and 3 of an ACC packet → `out_valid`=0 immediately. The next packet (2,3,c=1, last) outputs 7, not contaminated by the earlier partial sum.
